// File: rtl/cache_block_if.sv
// Command/result bundle for one cache_block instance.
// The master drives commands; the slave (the cache) returns registered results.
interface cache_block_if #(
  parameter int TW = 4,
  parameter int DW = 4
);
  logic              enable;
  logic [TW+DW+1:0]  vector_in;
  logic [DW-1:0]     data_out;
  logic              hit_miss_out;
  logic [TW-1:0]     tag_out_miss;
  logic [DW-1:0]     data_out_miss;

  modport master (
    output enable, vector_in,
    input  data_out, hit_miss_out,
    input  tag_out_miss, data_out_miss
  );

  modport slave (
    input  enable, vector_in,
    output data_out, hit_miss_out,
    output tag_out_miss, data_out_miss
  );
endinterface

// File: rtl/cache_block.sv
// Fully-associative cache array with round-robin victim pointer.
// One registered result per enabled command; victim line exposed on *_miss.
module cache_block #(
  parameter int CACHE_TAG_WIDTH  = 4,
  parameter int CACHE_DATA_WIDTH = 4,
  parameter int CACHE_ENTRIES    = 16,
  parameter int OPCODE_WIDTH     = 2
) (
  input  logic          clk,
  input  logic          reset,
  cache_block_if.slave  bus
);
  localparam int T  = CACHE_TAG_WIDTH;
  localparam int D  = CACHE_DATA_WIDTH;
  localparam int N  = CACHE_ENTRIES;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b10;
  localparam logic [1:0] OP_INV = 2'b11;

  logic [N-1:0]  valid_q, valid_d;
  logic [T-1:0]  tag_q  [N];
  logic [T-1:0]  tag_d  [N];
  logic [D-1:0]  data_q [N];
  logic [D-1:0]  data_d [N];
  logic [IW-1:0] ptr_q, ptr_d;
  logic [D-1:0]  dout_q, dout_d;
  logic          hit_q, hit_d;
  logic [T-1:0]  tmiss_q, tmiss_d;
  logic [D-1:0]  dmiss_q, dmiss_d;

  logic [OPCODE_WIDTH-1:0] op;
  logic [T-1:0]  tag_in;
  logic [D-1:0]  data_in;
  logic          hit_any, free_any;
  logic [IW-1:0] hit_idx, free_idx, alloc_idx;
  logic [T-1:0]  vic_tag;
  logic [D-1:0]  vic_data;

  assign op      = bus.vector_in[T+D+1 -: 2];
  assign tag_in  = bus.vector_in[T+D-1 -: T];
  assign data_in = bus.vector_in[D-1:0];

  // Downward scans so the lowest index wins.
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == tag_in) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
    end
    alloc_idx = free_any ? free_idx : ptr_q;
    vic_tag   = valid_q[alloc_idx] ? tag_q[alloc_idx] : '0;
    vic_data  = valid_q[alloc_idx] ? data_q[alloc_idx] : '0;
  end

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    dout_d  = dout_q;
    hit_d   = hit_q;
    tmiss_d = tmiss_q;
    dmiss_d = dmiss_q;
    if (bus.enable) begin
      case (op)
        OP_RD: begin
          hit_d = hit_any;
          if (hit_any) begin
            dout_d = data_q[hit_idx];
          end else begin
            tmiss_d = vic_tag;
            dmiss_d = vic_data;
          end
        end
        OP_WR: begin
          hit_d  = 1'b1;
          dout_d = data_in;
          if (hit_any) begin
            data_d[hit_idx] = data_in;
          end else begin
            valid_d[alloc_idx] = 1'b1;
            tag_d[alloc_idx]   = tag_in;
            data_d[alloc_idx]  = data_in;
            tmiss_d = vic_tag;
            dmiss_d = vic_data;
            if (!free_any) begin
              ptr_d = (ptr_q == IW'(N - 1)) ? '0
                    : ptr_q + 1'b1;
            end
          end
        end
        OP_INV: begin
          hit_d = hit_any;
          if (hit_any) valid_d[hit_idx] = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < N; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
      ptr_q   <= '0;
      dout_q  <= '0;
      hit_q   <= 1'b0;
      tmiss_q <= '0;
      dmiss_q <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      dout_q  <= dout_d;
      hit_q   <= hit_d;
      tmiss_q <= tmiss_d;
      dmiss_q <= dmiss_d;
    end
  end

  assign bus.data_out      = dout_q;
  assign bus.hit_miss_out  = hit_q;
  assign bus.tag_out_miss  = tmiss_q;
  assign bus.data_out_miss = dmiss_q;
endmodule

// File: tb/tb_cache_block.sv
// Directed bench: 16-entry cache (5-bit tags) and 1-entry cache.
// Expected values are hand-derived per step.
module tb_cache_block;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cache_block_if #(.TW(5), .DW(4)) ia ();
  cache_block_if #(.TW(4), .DW(4)) ib ();

  cache_block #(5, 4, 16) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (ia.slave)
  );

  cache_block #(4, 4, 1) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (ib.slave)
  );

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] RD  = 2'b01;
  localparam logic [1:0] WR  = 2'b10;
  localparam logic [1:0] INV = 2'b11;

  task automatic chk(input string nm,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             nm, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cmd_a(input logic en, input logic [1:0] op,
                       input logic [4:0] tg,
                       input logic [3:0] dt);
    ia.enable    = en;
    ia.vector_in = {op, tg, dt};
    tick();
    ia.enable    = 1'b0;
  endtask

  task automatic cmd_b(input logic [1:0] op,
                       input logic [3:0] tg,
                       input logic [3:0] dt);
    ib.enable    = 1'b1;
    ib.vector_in = {op, tg, dt};
    tick();
    ib.enable    = 1'b0;
  endtask

  task automatic chk_a(input string nm, input logic h,
                       input logic [3:0] d,
                       input logic [4:0] mt,
                       input logic [3:0] md);
    chk({nm, ".hit"},   32'(ia.hit_miss_out),  32'(h));
    chk({nm, ".dout"},  32'(ia.data_out),      32'(d));
    chk({nm, ".mtag"},  32'(ia.tag_out_miss),  32'(mt));
    chk({nm, ".mdata"}, 32'(ia.data_out_miss), 32'(md));
  endtask

  initial begin
    ia.enable = 1'b0; ia.vector_in = '0;
    ib.enable = 1'b0; ib.vector_in = '0;
    rst_a = 1'b1; rst_b = 1'b1;
    cmd_a(1'b1, WR, 5'h3, 4'h9);
    chk_a("reset_a", 1'b0, 4'h0, 5'h0, 4'h0);
    chk("reset_b.hit",  32'(ib.hit_miss_out),  0);
    chk("reset_b.dout", 32'(ib.data_out),      0);
    rst_a = 1'b0; rst_b = 1'b0;

    cmd_a(1'b1, RD, 5'h3, 4'h0);
    chk_a("rd_empty", 1'b0, 4'h0, 5'h0, 4'h0);

    cmd_a(1'b1, WR, 5'hC, 4'hF);
    chk_a("wr_c", 1'b1, 4'hF, 5'h0, 4'h0);
    cmd_a(1'b1, RD, 5'hC, 4'h0);
    chk_a("rd_c", 1'b1, 4'hF, 5'h0, 4'h0);

    cmd_a(1'b1, WR, 5'h5, 4'h3);
    chk_a("wr_5", 1'b1, 4'h3, 5'h0, 4'h0);
    cmd_a(1'b1, RD, 5'h7, 4'h0);
    chk_a("rd_miss7", 1'b0, 4'h3, 5'h0, 4'h0);
    cmd_a(1'b0, RD, 5'hC, 4'h0);
    chk_a("en0_rd_c", 1'b0, 4'h3, 5'h0, 4'h0);
    cmd_a(1'b1, RD, 5'hC, 4'h0);
    chk_a("en1_rd_c", 1'b1, 4'hF, 5'h0, 4'h0);
    cmd_a(1'b1, NOP, 5'h0, 4'h0);
    chk_a("nop_hold1", 1'b1, 4'hF, 5'h0, 4'h0);

    cmd_a(1'b1, INV, 5'h5, 4'h0);
    chk_a("inv_5", 1'b1, 4'hF, 5'h0, 4'h0);
    cmd_a(1'b1, RD, 5'h5, 4'h0);
    chk_a("rd_inv5", 1'b0, 4'hF, 5'h0, 4'h0);
    cmd_a(1'b1, INV, 5'h5, 4'h0);
    chk("inv_5_again.hit", 32'(ia.hit_miss_out), 0);
    cmd_a(1'b1, NOP, 5'h0, 4'h0);
    chk("nop_hold0.hit", 32'(ia.hit_miss_out), 0);

    rst_a = 1'b1;
    cmd_a(1'b1, WR, 5'hA, 4'h7);
    rst_a = 1'b0;
    chk_a("rst_wr_a", 1'b0, 4'h0, 5'h0, 4'h0);
    cmd_a(1'b1, RD, 5'hA, 4'h0);
    chk_a("rd_a_dropped", 1'b0, 4'h0, 5'h0, 4'h0);
    cmd_a(1'b1, RD, 5'hC, 4'h0);
    chk("rd_c_cleared.hit", 32'(ia.hit_miss_out), 0);

    for (int i = 0; i < 16; i++) begin
      cmd_a(1'b1, WR, 5'(i), 4'(i));
      chk("fill.hit",   32'(ia.hit_miss_out), 1);
      chk("fill.dout",  32'(ia.data_out),     32'(i));
      chk("fill.mtag",  32'(ia.tag_out_miss), 0);
    end
    cmd_a(1'b1, WR, 5'h0, 4'h5);
    chk_a("wr_hit_0", 1'b1, 4'h5, 5'h0, 4'h0);
    cmd_a(1'b1, WR, 5'h10, 4'h9);
    chk_a("evict_l0", 1'b1, 4'h9, 5'h0, 4'h5);
    for (int i = 1; i < 16; i++) begin
      cmd_a(1'b1, WR, 5'(16 + i), 4'hA);
      chk("rr.mtag",  32'(ia.tag_out_miss),  32'(i));
      chk("rr.mdata", 32'(ia.data_out_miss), 32'(i));
    end
    cmd_a(1'b1, WR, 5'h0, 4'h2);
    chk_a("wrap_l0", 1'b1, 4'h2, 5'h10, 4'h9);
    cmd_a(1'b1, RD, 5'h1, 4'h0);
    chk_a("rd_miss_vic", 1'b0, 4'h2, 5'h11, 4'hA);
    cmd_a(1'b1, RD, 5'h0, 4'h0);
    chk_a("rd_0", 1'b1, 4'h2, 5'h11, 4'hA);

    cmd_b(WR, 4'hC, 4'hF);
    chk("b_wr_c.hit",   32'(ib.hit_miss_out),  1);
    chk("b_wr_c.mtag",  32'(ib.tag_out_miss),  0);
    cmd_b(WR, 4'hD, 4'h0);
    chk("b_wr_d.dout",  32'(ib.data_out),      0);
    chk("b_wr_d.mtag",  32'(ib.tag_out_miss),  32'hC);
    chk("b_wr_d.mdata", 32'(ib.data_out_miss), 32'hF);
    cmd_b(RD, 4'hC, 4'h0);
    chk("b_rd_c.hit",   32'(ib.hit_miss_out),  0);
    chk("b_rd_c.mtag",  32'(ib.tag_out_miss),  32'hD);
    chk("b_rd_c.mdata", 32'(ib.data_out_miss), 0);
    cmd_b(RD, 4'hD, 4'h0);
    chk("b_rd_d.hit",   32'(ib.hit_miss_out),  1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
